// File: rtl/tnn_pkg.sv
// Shared definitions for the ternary neural-network datapath: weight codes,
// accumulator sizing and the serial neuron's FSM states.
package tnn_pkg;

    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b11;
    localparam logic [1:0] W_RSV  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } tnn_state_e;

    // Magnitude of N_IN full-scale products plus one bit for the sign.
    function automatic int tnn_acc_w(input int n_in, input int in_w);
        return in_w + $clog2(n_in + 1) + 1;
    endfunction

endpackage

// File: rtl/tnn_lane_mac.sv
// Combinational ternary multiply-accumulate across one beat of LANES features.
// Masked-off lanes and reserved weight codes contribute nothing to the sum.
module tnn_lane_mac
    import tnn_pkg::*;
#(
    parameter int LANES = 1,
    parameter int IN_W  = 2,
    parameter int ACC_W = 6
) (
    input  logic [LANES*IN_W-1:0]  x,
    input  logic [2*LANES-1:0]     w,
    input  logic [LANES-1:0]       lane_en,
    output logic signed [ACC_W-1:0] psum,
    output logic                   rsv
);

    always_comb begin
        psum = '0;
        rsv  = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (lane_en[l]) begin
                case (w[2*l +: 2])
                    W_POS:   psum = psum + $signed({{(ACC_W-IN_W){1'b0}}, x[l*IN_W +: IN_W]});
                    W_NEG:   psum = psum - $signed({{(ACC_W-IN_W){1'b0}}, x[l*IN_W +: IN_W]});
                    W_RSV:   rsv  = 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/tnn_serial_neuron.sv
// Sequential ternary-weight neuron: captures one vector per handshake, folds it
// LANES features per beat, then holds a registered decision and margin.
module tnn_serial_neuron
    import tnn_pkg::*;
#(
    parameter int N_IN    = 5,
    parameter int IN_W    = 2,
    parameter int LANES   = 1,
    parameter bit TIE_OUT = 1'b0,
    localparam int ACC_W  = tnn_acc_w(N_IN, IN_W)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [N_IN*IN_W-1:0]    s_data,
    input  logic [2*N_IN-1:0]       s_wgt,
    input  logic [ACC_W-1:0]        s_thr,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_bit,
    output logic signed [ACC_W-1:0] m_margin,
    output logic                    m_err
);

    localparam int BEATS  = (N_IN + LANES - 1) / LANES;
    localparam int PAD_N  = BEATS * LANES;
    localparam int DATA_W = PAD_N * IN_W;
    localparam int WGT_W  = 2 * PAD_N;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [PAD_N-1:0] VLD_INIT = PAD_N'({N_IN{1'b1}});

    tnn_state_e state_q;
    tnn_state_e state_d;

    logic [DATA_W-1:0]       data_q;
    logic [WGT_W-1:0]        wgt_q;
    logic [PAD_N-1:0]        vld_q;
    logic signed [ACC_W-1:0] thr_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [BEAT_W-1:0]       beat_q;
    logic                    err_q;

    logic                    load;
    logic                    beat_en;
    logic                    last_beat;
    logic signed [ACC_W-1:0] lane_psum;
    logic                    lane_rsv;
    logic signed [ACC_W-1:0] beat_sum;
    logic signed [ACC_W-1:0] margin;
    logic                    margin_pos;
    logic                    margin_zero;
    logic                    decision;

    tnn_lane_mac #(
        .LANES (LANES),
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_lane_mac (
        .x       (data_q[LANES*IN_W-1:0]),
        .w       (wgt_q[2*LANES-1:0]),
        .lane_en (vld_q[LANES-1:0]),
        .psum    (lane_psum),
        .rsv     (lane_rsv)
    );

    assign last_beat   = (beat_q == BEAT_W'(BEATS - 1));
    assign beat_sum    = acc_q + lane_psum;
    assign margin      = beat_sum - thr_q;
    assign margin_zero = (margin == '0);
    assign margin_pos  = !margin[ACC_W-1] && !margin_zero;
    assign decision    = margin_pos || (margin_zero && TIE_OUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        m_valid = 1'b0;
        load    = 1'b0;
        beat_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    load    = 1'b1;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                beat_en = 1'b1;
                if (last_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture registers shift one beat per cycle so lane 0..LANES-1 always
    // holds the current slice; the valid mask shifts alongside to blank padding.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            wgt_q    <= '0;
            vld_q    <= '0;
            thr_q    <= '0;
            acc_q    <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
            m_bit    <= 1'b0;
            m_margin <= '0;
            m_err    <= 1'b0;
        end else if (load) begin
            data_q <= DATA_W'(s_data);
            wgt_q  <= WGT_W'(s_wgt);
            vld_q  <= VLD_INIT;
            thr_q  <= s_thr;
            acc_q  <= '0;
            beat_q <= '0;
            err_q  <= 1'b0;
        end else if (beat_en) begin
            data_q <= data_q >> (LANES * IN_W);
            wgt_q  <= wgt_q >> (2 * LANES);
            vld_q  <= vld_q >> LANES;
            acc_q  <= beat_sum;
            beat_q <= beat_q + BEAT_W'(1);
            err_q  <= err_q | lane_rsv;
            if (last_beat) begin
                m_bit    <= decision;
                m_margin <= margin;
                m_err    <= err_q | lane_rsv;
            end
        end
    end

endmodule

// File: tb/tb_tnn_serial_neuron.sv
// Bench for tnn_serial_neuron: three instances (LANES=1, LANES=1 with TIE_OUT=1,
// LANES=2) against a transaction-level reference, plus literal test-plan cases.
module tb_tnn_serial_neuron;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic [9:0] s_data;
    logic [9:0] s_wgt;
    logic [5:0] s_thr;
    logic       m_ready;

    wire [NI-1:0] s_ready;
    wire [NI-1:0] m_valid;
    wire [NI-1:0] m_bit;
    wire [NI-1:0] m_err;
    wire [5:0]    m_margin [NI];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tnn_serial_neuron #(.N_IN(5), .IN_W(2), .LANES(1), .TIE_OUT(1'b0)) dut_l1 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready[0]),
        .s_data(s_data), .s_wgt(s_wgt), .s_thr(s_thr), .m_valid(m_valid[0]),
        .m_ready(m_ready), .m_bit(m_bit[0]), .m_margin(m_margin[0]), .m_err(m_err[0])
    );

    tnn_serial_neuron #(.N_IN(5), .IN_W(2), .LANES(1), .TIE_OUT(1'b1)) dut_tie (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready[1]),
        .s_data(s_data), .s_wgt(s_wgt), .s_thr(s_thr), .m_valid(m_valid[1]),
        .m_ready(m_ready), .m_bit(m_bit[1]), .m_margin(m_margin[1]), .m_err(m_err[1])
    );

    tnn_serial_neuron #(.N_IN(5), .IN_W(2), .LANES(2), .TIE_OUT(1'b0)) dut_l2 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready[2]),
        .s_data(s_data), .s_wgt(s_wgt), .s_thr(s_thr), .m_valid(m_valid[2]),
        .m_ready(m_ready), .m_bit(m_bit[2]), .m_margin(m_margin[2]), .m_err(m_err[2])
    );

    function automatic int beatsOf(input int i);
        return (i == 2) ? 3 : 5;
    endfunction

    function automatic int tieOf(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    function automatic int refMargin(input logic [9:0] d, input logic [9:0] w, input logic [5:0] t);
        int sum = 0;
        for (int k = 0; k < 5; k++) begin
            int x = int'(d[2*k +: 2]);
            case (w[2*k +: 2])
                2'b01:   sum = sum + x;
                2'b11:   sum = sum - x;
                default: ;
            endcase
        end
        return sum - int'($signed(t));
    endfunction

    function automatic int refErr(input logic [9:0] w);
        int e = 0;
        for (int k = 0; k < 5; k++) begin
            if (w[2*k +: 2] == 2'b10) e = 1;
        end
        return e;
    endfunction

    function automatic int expBit(input int mg, input int tie);
        return (mg > 0) ? 1 : ((mg == 0) ? tie : 0);
    endfunction

    int ref_margin;
    int ref_err;
    assign ref_margin = refMargin(s_data, s_wgt, s_thr);
    assign ref_err    = refErr(s_wgt);

    // Transaction-level reference: a vector accepted at edge t is due at edge
    // t+C and then held until the consumer takes it.
    int cyc = 0;
    bit mdl_busy   [NI];
    bit mdl_done   [NI];
    int mdl_due    [NI];
    int mdl_margin [NI];
    int mdl_err    [NI];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                mdl_busy[i] <= 1'b0;
                mdl_done[i] <= 1'b0;
            end else if (!mdl_busy[i] && !mdl_done[i]) begin
                if (s_valid) begin
                    mdl_busy[i]   <= 1'b1;
                    mdl_due[i]    <= cyc + beatsOf(i);
                    mdl_margin[i] <= ref_margin;
                    mdl_err[i]    <= ref_err;
                end
            end else if (mdl_busy[i]) begin
                if (cyc == mdl_due[i]) begin
                    mdl_busy[i] <= 1'b0;
                    mdl_done[i] <= 1'b1;
                end
            end else if (m_ready) begin
                mdl_done[i] <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input int idx,
                               input logic signed [31:0] actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s[%0d] actual=%0d required=%0d at cycle %0d",
                     name, idx, actual, expected, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (s_valid && !rst) begin
            checkOutput("margin_in_range", 0, ref_margin >= -32 && ref_margin <= 31, 1);
        end
        for (int i = 0; i < NI; i++) begin
            checkOutput("s_ready", i, s_ready[i], (mdl_busy[i] || mdl_done[i]) ? 0 : 1);
            checkOutput("m_valid", i, m_valid[i], mdl_done[i] ? 1 : 0);
            if (mdl_done[i]) begin
                checkOutput("m_margin", i, $signed(m_margin[i]), mdl_margin[i]);
                checkOutput("m_bit", i, m_bit[i], expBit(mdl_margin[i], tieOf(i)));
                checkOutput("m_err", i, m_err[i], mdl_err[i]);
            end
        end
    end

    task automatic applyStimulus(input logic [9:0] d, input logic [9:0] w, input int thr);
        int n = 0;
        while (s_ready !== 3'b111 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) checkOutput("accept_wait", 0, n, 0);
        s_data  = d;
        s_wgt   = w;
        s_thr   = 6'(thr);
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic waitAll(output int lat0, output int lat1, output int lat2);
        int n = 0;
        lat0 = -1;
        lat1 = -1;
        lat2 = -1;
        while ((lat0 < 0 || lat1 < 0 || lat2 < 0) && n < 40) begin
            @(negedge clk);
            n++;
            if (lat0 < 0 && m_valid[0] === 1'b1) lat0 = n;
            if (lat1 < 0 && m_valid[1] === 1'b1) lat1 = n;
            if (lat2 < 0 && m_valid[2] === 1'b1) lat2 = n;
        end
        if (n >= 40) checkOutput("result_wait", 0, n, 0);
    endtask

    task automatic checkResult(input string tag, input int mg, input int b0, input int b1,
                               input int b2, input int err);
        int bits [NI];
        bits = '{b0, b1, b2};
        for (int i = 0; i < NI; i++) begin
            checkOutput({tag, "_margin"}, i, $signed(m_margin[i]), mg);
            checkOutput({tag, "_bit"}, i, m_bit[i], bits[i]);
            checkOutput({tag, "_err"}, i, m_err[i], err);
            checkOutput({tag, "_model"}, i, mdl_margin[i], mg);
        end
    endtask

    task automatic handshake();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        for (int i = 0; i < NI; i++) begin
            checkOutput({tag, "_s_ready"}, i, s_ready[i], 1);
            checkOutput({tag, "_m_valid"}, i, m_valid[i], 0);
            checkOutput({tag, "_m_bit"}, i, m_bit[i], 0);
            checkOutput({tag, "_m_margin"}, i, $signed(m_margin[i]), 0);
            checkOutput({tag, "_m_err"}, i, m_err[i], 0);
        end
    endtask

    // Feature a is bits [1:0]; weights (a..e) = (-1,+1,-1,+1,-1).
    localparam logic [9:0] W_BASE = 10'b11_01_11_01_11;
    localparam logic [9:0] W_RSVB = 10'b11_01_11_10_11;
    localparam logic [9:0] X_BASE = 10'b00_11_00_11_00;
    localparam logic [9:0] X_TIE  = 10'b00_00_00_01_01;
    localparam logic [9:0] X_EXT  = 10'b11_00_11_00_11;

    initial begin
        int l0, l1, l2;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_wgt   = '0;
        s_thr   = '0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(X_BASE, W_BASE, 0);
        waitAll(l0, l1, l2);
        checkOutput("base_latency", 0, l0, 5);
        checkOutput("base_latency", 1, l1, 5);
        checkOutput("pad_latency", 2, l2, 3);
        checkResult("base", 6, 1, 1, 1, 0);
        handshake();

        applyStimulus(X_TIE, W_BASE, 0);
        waitAll(l0, l1, l2);
        checkResult("tie", 0, 0, 1, 0, 0);
        handshake();

        applyStimulus(X_EXT, W_BASE, 0);
        waitAll(l0, l1, l2);
        checkResult("extreme", -9, 0, 0, 0, 0);
        handshake();

        applyStimulus(X_BASE, W_RSVB, 0);
        waitAll(l0, l1, l2);
        checkResult("reserved", 3, 1, 1, 1, 1);
        handshake();

        applyStimulus(X_BASE, W_BASE, 0);
        waitAll(l0, l1, l2);
        checkResult("clean_after_rsv", 6, 1, 1, 1, 0);
        handshake();

        applyStimulus(X_BASE, W_BASE, 2);
        waitAll(l0, l1, l2);
        for (int c = 0; c < 10; c++) begin
            s_data = 10'($urandom);
            s_wgt  = 10'($urandom);
            s_thr  = 6'(int'($urandom_range(0, 32)) - 16);
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                checkOutput("hold_s_ready", i, s_ready[i], 0);
                checkOutput("hold_m_valid", i, m_valid[i], 1);
                checkOutput("hold_margin", i, $signed(m_margin[i]), 4);
                checkOutput("hold_bit", i, m_bit[i], 1);
            end
        end
        handshake();
        for (int i = 0; i < NI; i++) checkOutput("release_s_ready", i, s_ready[i], 1);

        applyStimulus(X_BASE, W_BASE, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkResetValues("mid_reset");
        rst = 1'b0;
        applyStimulus(X_EXT, W_BASE, 0);
        waitAll(l0, l1, l2);
        checkResult("after_reset", -9, 0, 0, 0, 0);
        handshake();

        for (int c = 0; c < 600; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 10'($urandom);
            s_wgt   = 10'($urandom);
            s_thr   = 6'(int'($urandom_range(0, 32)) - 16);
            m_ready = ($urandom_range(0, 2) != 0);
            rst     = ($urandom_range(0, 59) == 0);
            @(negedge clk);
        end
        rst     = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
